// File: rtl/block_zigzag_reader.sv
// Single-block 64-entry buffer: fills in raster order, drains in JPEG zigzag order.
// Define ZIGZAG_EN for zigzag readout; otherwise the block drains in raster order.
module block_zigzag_reader #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [5:0]    wr_cnt;
    logic [5:0]    rd_cnt;
    logic [5:0]    rd_idx;
    logic          wr_fire;
    logic          rd_fire;
    logic [DW-1:0] mem [64];

`ifdef ZIGZAG_EN
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign rd_idx = ZZ_ROM[rd_cnt];
`else
    assign rd_idx = rd_cnt;
`endif

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (wr_fire && (wr_cnt == 6'd63)) state_nxt = DRAIN;
            DRAIN:   if (rd_fire && (rd_cnt == 6'd63)) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Handshake outputs depend on the registered state only, never on in_valid/out_ready.
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && (rd_cnt == 6'd63);
        busy      = (state == DRAIN) || (wr_cnt != 6'd0);
        out_idx   = rd_idx;
        out_data  = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + 6'd1;
            if (rd_fire) rd_cnt <= rd_cnt + 6'd1;
        end
    end

    // NOTE: the sample array has no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_cnt] <= in_data;
    end

endmodule

// File: tb/tb_block_zigzag_reader.sv
// Scoreboard bench for block_zigzag_reader: directed blocks, backpressure, input during
// drain, resets mid-fill/mid-drain and back-to-back throughput. Honors ZIGZAG_EN.
module tb_block_zigzag_reader;

    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          busy;

    block_zigzag_reader #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [5:0]    idx;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            map_tb [64];
    logic [DW-1:0] cur_blk [64];
    logic          last_ov;

    int zz_tb [64] = '{
        0,  1,  8,  16, 9,  2,  3,  10,
        17, 24, 32, 25, 18, 11, 4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13, 6,  7,  14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on each output handshake and checks stall stability.
    initial begin : monitor
        logic          held;
        logic [DW-1:0] h_data;
        logic [5:0]    h_idx;
        logic          h_last;
        exp_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || !out_valid) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_data", out_data, h_data);
                    check("hold_idx", out_idx, h_idx);
                    check("hold_last", out_last, h_last);
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        check("sb_underflow", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                    end
                end else begin
                    held   = 1'b1;
                    h_data = out_data;
                    h_idx  = out_idx;
                    h_last = out_last;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("fill_wait", in_ready, 1);
        last_ov = out_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            cur_blk[k] = DW'(base + k);
            send(cur_blk[k]);
        end
        in_valid = 1'b0;
        if (n == 64) begin
            check("ov_before_last_write", last_ov, 0);
            check("ov_after_last_write", out_valid, 1);
            check("ir_after_last_write", in_ready, 0);
            for (int k = 0; k < 64; k++) begin
                e.data = cur_blk[map_tb[k]];
                e.idx  = 6'(map_tb[k]);
                e.last = (k == 63);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int abort_at,
                         input bit hold_in);
        int k;
        int stalls;
        int guard;
        k = 0;
        stalls = 0;
        guard = 0;
        while (k < 64 && guard < 400) begin
            if (k == abort_at) break;
            out_ready = !(k == stall_at && stalls < stall_len);
            if (hold_in) begin
                in_valid = 1'b1;
                in_data  = 12'hABC;
            end
            @(negedge clk);
            if (hold_in) check("in_ready_in_drain", in_ready, 0);
            if (out_valid) begin
                if (out_ready) begin
                    k++;
                end else begin
                    stalls++;
                    check("stall_data", out_data, cur_blk[map_tb[k]]);
                    check("stall_idx", out_idx, map_tb[k]);
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) check("drain_timeout", k, 64);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_idx", out_idx, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int t0;
        for (int k = 0; k < 64; k++) begin
`ifdef ZIGZAG_EN
            map_tb[k] = zz_tb[k];
`else
            map_tb[k] = k;
`endif
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        check("por_in_ready", in_ready, 1);
        check("por_out_valid", out_valid, 0);
        check("por_out_last", out_last, 0);
        check("por_busy", busy, 0);
        check("por_out_idx", out_idx, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Block of k=0..63, stall 3 cycles at rd_cnt=5, junk input held through drain.
        fill(0, 64);
        drain(5, 3, -1, 1'b1);
        check("ir_after_drain_a", in_ready, 1);

        // Next block must be untouched by the junk input.
        fill(200, 64);
        drain(-1, 0, -1, 1'b0);

        // Reset after 20 writes, then a fresh block.
        fill(300, 20);
        check("busy_mid_fill", busy, 1);
        pulse_reset();
        fill(100, 64);
        drain(-1, 0, -1, 1'b0);

        // Reset mid-drain at rd_cnt=30, then a full block.
        fill(400, 64);
        drain(-1, 0, 30, 1'b0);
        check("busy_mid_drain", busy, 1);
        pulse_reset();
        fill(500, 64);
        drain(-1, 0, -1, 1'b0);

        // Two back-to-back blocks with both sides always ready.
        for (int b = 0; b < 2; b++) begin
            t0 = cyc;
            fill(600 + 100 * b, 64);
            drain(-1, 0, -1, 1'b0);
            check("ir_after_out_last", in_ready, 1);
            check("block_cycles", cyc - t0, 128);
        end

        repeat (2) @(posedge clk);
        check("sb_leftover", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_zigzag_reader.md
# block_zigzag_reader

Single-block 64-entry coefficient buffer that sits downstream of the raster-order 8x8 block writer in the image compression datapath. It accepts one 8x8 block of DW-bit samples in raster order (index 0..63) over a valid/ready input. It then plays the block back over a valid/ready output in JPEG zigzag order for the entropy/quantisation stage. Fill and drain alternate and never overlap.

## Interface
- DW, default 12: sample/coefficient width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block accepts a sample; high only in FILL.
- in_data  input  DW  sample; raster index = number of samples already accepted this block.
- out_valid  output  1  output sample valid; high only in DRAIN.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  DW  sample at raster index zz[rd_cnt].
- out_idx  output  6  raster index of the current out_data (zz[rd_cnt]).
- out_last  output  1  high with the 64th output sample (rd_cnt == 63).
- busy  output  1  high in DRAIN, or in FILL with wr_cnt != 0.

## Operation
- Storage: 64 x DW register array mem. Not reset; contents are don't-care until written.
- Counters: wr_cnt[5:0] and rd_cnt[5:0]. Both wrap naturally 63 -> 0.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: mem[wr_cnt] <= in_data and wr_cnt <= wr_cnt + 1.
  - When the accepted write has wr_cnt == 63: go to DRAIN; wr_cnt wraps to 0.
- State DRAIN:
  - in_ready = 0, and in_valid is ignored.
  - out_valid = 1.
  - out_data = mem[zz[rd_cnt]], read combinationally from the array.
  - out_idx = zz[rd_cnt].
  - On out_valid && out_ready: rd_cnt <= rd_cnt + 1.
  - When that transfer has rd_cnt == 63: go to FILL; rd_cnt wraps to 0.
- Stall rule: while out_valid && !out_ready, out_data, out_idx and out_last are held stable.
- Zigzag map zz (standard JPEG), 64-entry constant ROM:
  - zz[0..9] = 0,1,8,16,9,2,3,10,17,24.
  - zz[10..15] = 32,25,18,11,4,5.
  - zz[61..63] = 55,62,63.
- Reset (asserted at any time, including mid-fill or mid-drain):
  - Immediately: state = FILL, wr_cnt = 0, rd_cnt = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_idx = 0, out_data = don't-care.
  - Any partial block is discarded.

## Timing
- in_ready and out_valid are decoded from the registered state only; no combinational path from in_valid or out_ready.
- Latency: out_valid rises in the cycle after the 64th input handshake. The first sample is raster index 0.
- in_ready rises in the cycle after the out_last handshake.
- Minimum cycles per block: 64 fill + 64 drain = 128; no bubble beyond the single state change.
- Throughput with both sides always ready: one sample per cycle on each side in its phase.

## Configuration
- Macro: ZIGZAG_EN.
- Defined: readout uses the zz map above.
- Undefined: zz[k] = k, i.e. raster-order passthrough with identical handshake, latency and out_last behaviour.
- out_idx always reports the raster index actually emitted.

## Test plan
- Fill, ZIGZAG_EN defined, out_ready = 1: write in_data = k for k = 0..63. Required:
  - out_data sequence 0,1,8,16,9,2,3,10,17,24,...,55,62,63.
  - out_last only on 63.
  - out_valid first high exactly 1 cycle after the 64th write.
- Backpressure: deassert out_ready for 3 cycles at rd_cnt = 5. Required: out_data = 2 and out_idx = 2 held for all 3 cycles, and no sample is skipped or duplicated.
- Input during drain: hold in_valid = 1 with data 0xABC throughout DRAIN. Required: in_ready = 0, and the next block's mem contents are unaffected.
- Reset mid-fill: after 20 writes pulse rst low, then write 64 fresh samples 100+k. Required: the output is the zigzag order of 100..163 only.
- Reset mid-drain at rd_cnt = 30. Required: out_valid = 0 and in_ready = 1 immediately; the next full block drains correctly from index 0.
- ZIGZAG_EN undefined, two back-to-back blocks. Required:
  - Outputs are 0..63 in order.
  - in_ready rises the cycle after the first out_last.
  - Total 128 cycles per block with both sides always ready.
